// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default widths, accumulator FSM encoding
// and the saturating add used by the partial-sum accumulator.
package cnn_pkg;

  localparam int DEF_PSUM_W = 25;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] sum;
  } sat_sum_t;

  // Operands arrive sign-extended to 64 bits; the result is clamped to a signed
  // 'width'-bit range so callers can truncate it without wrapping.
  function automatic sat_sum_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] raw;
    sat_sum_t           res;
    hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    raw     = a + b;
    res.ovf = 1'b0;
    res.sum = raw;
    if (raw > hi) begin
      res.ovf = 1'b1;
      res.sum = hi;
    end else if (raw < lo) begin
      res.ovf = 1'b1;
      res.sum = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Partial-sum input stream and requantised output stream of the accumulator.
interface psum_accumulator_if #(
  parameter int PSUM_W = cnn_pkg::DEF_PSUM_W,
  parameter int OUT_W  = cnn_pkg::DEF_OUT_W
) ();

  logic signed [PSUM_W-1:0] psum_in;
  logic                     psum_valid;
  logic                     psum_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output psum_in, psum_valid, out_ready,
    input  psum_ready, out_data, out_valid
  );

  modport slave (
    input  psum_in, psum_valid, out_ready,
    output psum_ready, out_data, out_valid
  );

endinterface

// File: rtl/psum_requant.sv
// Combinational requantiser: round-half-up arithmetic shift, optional ReLU,
// then saturation to the signed output width.
module psum_requant
  import cnn_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] sum,
  input  logic        [4:0]       shift,
  input  logic                    relu,
  output logic signed [OUT_W-1:0] result
);

  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(-(1 <<< (OUT_W - 1)));

  logic signed [ACC_W:0] wide;
  logic signed [ACC_W:0] bias;
  logic signed [ACC_W:0] shifted;

  // One extra bit of headroom keeps the rounding bias from wrapping a
  // near-maximum sum into a negative value.
  always_comb begin
    wide = {sum[ACC_W-1], sum};
    bias = '0;
    if (shift != 5'd0) begin
      bias = (ACC_W+1)'(1) <<< (shift - 5'd1);
    end
    shifted = (wide + bias) >>> shift;
    if (relu && (shifted < 0)) begin
      shifted = '0;
    end
    if (shifted > OUT_MAX) begin
      result = OUT_W'(OUT_MAX);
    end else if (shifted < OUT_MIN) begin
      result = OUT_W'(OUT_MIN);
    end else begin
      result = OUT_W'(shifted);
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates cfg_num_tiles partial sums per output pixel and streams the
// requantised activations toward the ofmap buffer.
module psum_accumulator
  import cnn_pkg::*;
#(
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        cfg_num_tiles,
  input  logic [15:0]       cfg_num_outputs,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  psum_accumulator_if.slave stream,
  output logic              busy,
  output logic              done,
  output logic              acc_ovf
);

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic        [7:0]        tile_cnt;
  logic        [15:0]       out_cnt;
  logic        [7:0]        tiles;
  logic        [15:0]       outputs;
  logic        [4:0]        shift;
  logic                     relu;

  logic signed [PSUM_W-1:0] psum_word;
  sat_sum_t                 sat_res;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [OUT_W-1:0]  requant_out;
  logic                     accept;
  logic                     handshake;

  assign psum_word = stream.psum_in;
  assign accept    = stream.psum_valid && stream.psum_ready;
  assign handshake = stream.out_valid && stream.out_ready;

  always_comb begin
    sat_res = sat_add(64'(acc), 64'(psum_word), ACC_W);
    acc_sum = ACC_W'(sat_res.sum);
  end

  // The requantiser looks at acc + psum, so the final tile's result is
  // registered on the same edge that accepts it.
  psum_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_requant (
    .sum    (acc_sum),
    .shift  (shift),
    .relu   (relu),
    .result (requant_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      acc               <= '0;
      tile_cnt          <= '0;
      out_cnt           <= '0;
      tiles             <= '0;
      outputs           <= '0;
      shift             <= '0;
      relu              <= 1'b0;
      stream.psum_ready <= 1'b0;
      stream.out_data   <= '0;
      stream.out_valid  <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      acc_ovf           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tiles    <= (cfg_num_tiles == 8'd0) ? 8'd1 : cfg_num_tiles;
            outputs  <= cfg_num_outputs;
            shift    <= cfg_shift;
            relu     <= cfg_relu;
            acc_ovf  <= 1'b0;
            acc      <= '0;
            tile_cnt <= '0;
            out_cnt  <= '0;
            if (cfg_num_outputs == 16'd0) begin
              done <= 1'b1;
            end else begin
              state             <= ACCUM;
              stream.psum_ready <= 1'b1;
              busy              <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (accept) begin
            if (sat_res.ovf) begin
              acc_ovf <= 1'b1;
            end
            if (tile_cnt == tiles - 8'd1) begin
              stream.out_data   <= requant_out;
              stream.out_valid  <= 1'b1;
              stream.psum_ready <= 1'b0;
              acc               <= '0;
              tile_cnt          <= '0;
              state             <= EMIT;
            end else begin
              acc      <= acc_sum;
              tile_cnt <= tile_cnt + 8'd1;
            end
          end
        end

        EMIT: begin
          if (handshake) begin
            stream.out_valid <= 1'b0;
            if (out_cnt == outputs - 16'd1) begin
              done    <= 1'b1;
              out_cnt <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              out_cnt           <= out_cnt + 16'd1;
              stream.psum_ready <= 1'b1;
              state             <= ACCUM;
            end
          end
        end

        default: begin
          state             <= IDLE;
          stream.psum_ready <= 1'b0;
          stream.out_valid  <= 1'b0;
          busy              <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed and randomized checks of psum_accumulator against a plain-arithmetic
// model of accumulate, saturate and requantise.
module tb_psum_accumulator;
  import cnn_pkg::*;

  localparam longint ACC_MAX = 64'sd2147483647;
  localparam longint ACC_MIN = -64'sd2147483648;
  localparam longint OUT_MAX = 64'sd127;
  localparam longint OUT_MIN = -64'sd128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start;
  logic [7:0]  cfg_num_tiles;
  logic [15:0] cfg_num_outputs;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic        busy;
  logic        done;
  logic        acc_ovf;

  int checks = 0;
  int errors = 0;

  psum_accumulator_if bus ();

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .cfg_num_tiles   (cfg_num_tiles),
    .cfg_num_outputs (cfg_num_outputs),
    .cfg_shift       (cfg_shift),
    .cfg_relu        (cfg_relu),
    .stream          (bus),
    .busy            (busy),
    .done            (done),
    .acc_ovf         (acc_ovf)
  );

  task automatic check_output(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: saturating running sum per tile, then round-half-up shift,
  // ReLU and clamp to the 8-bit range.
  function automatic longint model_out(input longint ps[$], input int sh, input bit relu,
                                       output bit ovf);
    longint acc;
    longint r;
    acc = 0;
    ovf = 1'b0;
    foreach (ps[i]) begin
      acc = acc + ps[i];
      if (acc > ACC_MAX) begin
        acc = ACC_MAX;
        ovf = 1'b1;
      end else if (acc < ACC_MIN) begin
        acc = ACC_MIN;
        ovf = 1'b1;
      end
    end
    r = acc + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
    r = r >>> sh;
    if (relu && r < 0) r = 0;
    if (r > OUT_MAX) r = OUT_MAX;
    if (r < OUT_MIN) r = OUT_MIN;
    return r;
  endfunction

  task automatic start_job(input int tiles, input int outputs, input int sh, input bit relu);
    cfg_num_tiles   = 8'(tiles);
    cfg_num_outputs = 16'(outputs);
    cfg_shift       = 5'(sh);
    cfg_relu        = relu;
    start           = 1'b1;
    @(negedge clk);
    start           = 1'b0;
  endtask

  task automatic apply_stimulus(input longint v);
    int waited;
    waited         = 0;
    bus.psum_in    = 25'(v);
    bus.psum_valid = 1'b1;
    while (!bus.psum_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.psum_ready) check_output("psum_ready_wait", bus.psum_ready, 1);
    @(negedge clk);
    bus.psum_valid = 1'b0;
  endtask

  task automatic take_output(input string tag, input longint exp_data, input int stall,
                             input bit last);
    int waited;
    waited = 0;
    while (!bus.out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_output({tag, "_valid"}, bus.out_valid, 1);
    check_output({tag, "_data"}, $signed(bus.out_data), exp_data);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_output({tag, "_hold_data"}, $signed(bus.out_data), exp_data);
      check_output({tag, "_hold_valid"}, bus.out_valid, 1);
      check_output({tag, "_hold_ready"}, bus.psum_ready, 0);
      check_output({tag, "_hold_done"}, done, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_output({tag, "_done"}, done, last);
    check_output({tag, "_busy"}, busy, !last);
  endtask

  initial begin
    bus.psum_in     = '0;
    bus.psum_valid  = 1'b0;
    bus.out_ready   = 1'b0;
    start           = 1'b0;
    cfg_num_tiles   = '0;
    cfg_num_outputs = '0;
    cfg_shift       = '0;
    cfg_relu        = 1'b0;

    repeat (2) @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_acc_ovf", acc_ovf, 0);
    check_output("rst_psum_ready", bus.psum_ready, 0);
    check_output("rst_out_valid", bus.out_valid, 0);
    check_output("rst_out_data", bus.out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic accumulation with single-cycle result latency.
    start_job(4, 1, 0, 0);
    check_output("t1_busy", busy, 1);
    apply_stimulus(100);
    apply_stimulus(-30);
    apply_stimulus(7);
    apply_stimulus(1);
    check_output("t1_latency", bus.out_valid, 1);
    take_output("t1", 78, 0, 1);

    // Rounding, downstream stall on output 2, and start ignored mid-job.
    start_job(2, 3, 4, 0);
    apply_stimulus(1000);
    apply_stimulus(24);
    take_output("t2_o1", 64, 0, 0);
    apply_stimulus(1000);
    apply_stimulus(32);
    take_output("t2_o2", 65, 5, 0);
    apply_stimulus(-20);
    start_job(1, 1, 0, 1);
    check_output("t2_start_ignored", bus.out_valid, 0);
    apply_stimulus(-20);
    take_output("t2_o3", -2, 0, 1);

    // ReLU and saturation.
    start_job(1, 2, 0, 1);
    apply_stimulus(-5);
    take_output("relu_neg", 0, 0, 0);
    apply_stimulus(300);
    take_output("sat_pos", 127, 1, 1);
    start_job(1, 1, 0, 0);
    apply_stimulus(-300);
    take_output("sat_neg", -128, 0, 1);

    // Zero tiles behaves as one tile.
    start_job(0, 2, 0, 0);
    apply_stimulus(42);
    take_output("tiles0_a", 42, 0, 0);
    apply_stimulus(-7);
    take_output("tiles0_b", -7, 0, 1);

    // Zero outputs: done next cycle without going busy.
    start_job(3, 0, 0, 0);
    check_output("out0_done", done, 1);
    check_output("out0_busy", busy, 0);
    @(negedge clk);
    check_output("out0_done_pulse", done, 0);

    // Accumulator saturation with a large shift exercising the wide rounding add.
    begin
      longint ps[$];
      longint expv;
      bit     ovf;
      ps.delete();
      start_job(255, 1, 31, 0);
      for (int t = 0; t < 255; t++) begin
        ps.push_back(64'sd16777215);
        apply_stimulus(64'sd16777215);
      end
      expv = model_out(ps, 31, 1'b0, ovf);
      take_output("accsat", expv, 0, 1);
      check_output("accsat_ovf", acc_ovf, ovf);
      start_job(1, 0, 0, 0);
      check_output("accsat_ovf_clear", acc_ovf, 0);
    end

    // Reset in the middle of accumulation.
    start_job(4, 1, 0, 0);
    apply_stimulus(500);
    apply_stimulus(600);
    rst_n = 1'b0;
    #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_psum_ready", bus.psum_ready, 0);
    check_output("midrst_out_valid", bus.out_valid, 0);
    check_output("midrst_out_data", bus.out_data, 0);
    check_output("midrst_done", done, 0);
    @(negedge clk);
    check_output("midrst_busy_low", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(1, 1, 0, 0);
    apply_stimulus(9);
    take_output("midrst_restart", 9, 0, 1);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 10; j++) begin
      int tiles;
      int eff;
      int outs;
      int sh;
      bit rl;
      bit job_ovf;
      tiles   = $urandom_range(5, 0);
      eff     = (tiles == 0) ? 1 : tiles;
      outs    = $urandom_range(3, 1);
      sh      = $urandom_range(16, 0);
      rl      = 1'($urandom_range(1, 0));
      job_ovf = 1'b0;
      start_job(tiles, outs, sh, rl);
      for (int o = 0; o < outs; o++) begin
        longint ps[$];
        longint expv;
        longint v;
        bit     ovf;
        ps.delete();
        for (int t = 0; t < eff; t++) begin
          v = longint'($urandom_range(33554431, 0)) - 64'sd16777216;
          ps.push_back(v);
          apply_stimulus(v);
        end
        expv    = model_out(ps, sh, rl, ovf);
        job_ovf = job_ovf | ovf;
        take_output($sformatf("rnd%0d_%0d", j, o), expv, $urandom_range(2, 0), o == outs - 1);
      end
      check_output($sformatf("rnd%0d_ovf", j), acc_ovf, job_ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
